rr_arb3_ctrl: RTL and testbench

Three-requester round-robin arbiter that shares one downstream resource between request lines `a`, `b`, `c` (bits 0, 1, 2 of `req`). It issues a registered one-hot grant and holds it until the owner signals `done` or drops its request. It always inserts one dead cycle between owners, and can optionally force release after a bounded hold time. It sits between the stimulus/requester logic and the shared resource in the exp4 coverage design.

---
 rtl/rr_arb3_ctrl.sv | 110 +++++++++++
 tb/tb_rr_arb3_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb3_ctrl.sv
// rr_arb3_ctrl: three-requester round-robin arbiter with a registered one-hot
// grant, one dead cycle between owners and an optional hold-time limit.
// Optional feature macro: RR_ARB3_TIMEOUT_EN (forced release after HOLD_MAX
// grant cycles, reported by a one-cycle timeout pulse).
//
// Handshake: a requester holds req[i] high until it is granted. gnt[i] stays
// high while req[i] is held and done is low. Dropping req[i] or pulsing done
// for one cycle ends ownership at the next edge. gnt is registered, so it
// reflects the req/done values sampled at the previous rising edge.
module rr_arb3_ctrl #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [2:0]       req,
  input  logic             done,
  output logic [2:0]       gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

`ifdef RR_ARB3_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Counter value seen in the last permitted grant cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             owner_req;
  logic             rel_normal;
  logic             hold_hit;

  // First requester after the previous owner, in circular order.
  always_comb begin
    pick = 2'd0;
    case (last)
      2'd0:    if (req[1]) pick = 2'd1; else if (req[2]) pick = 2'd2; else pick = 2'd0;
      2'd1:    if (req[2]) pick = 2'd2; else if (req[0]) pick = 2'd0; else pick = 2'd1;
      default: if (req[0]) pick = 2'd0; else if (req[1]) pick = 2'd1; else pick = 2'd2;
    endcase
  end

  // Release conditions while granted; done/drop take precedence over timeout.
  always_comb begin
    owner_req  = |(req & gnt);
    rel_normal = done | ~owner_req;
    hold_hit   = TIMEOUT_EN && (cnt == HOLD_LAST);
  end

  // Arbiter FSM with registered grant, owner, busy and timeout outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      gnt     <= 3'b000;
      owner   <= 2'b11;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= 2'd2;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE, S_GAP: begin
          if (|req) begin
            gnt   <= 3'b001 << pick;
            owner <= pick;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= S_GRANT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (rel_normal || hold_hit) begin
            last    <= owner;
            gnt     <= 3'b000;
            owner   <= 2'b11;
            busy    <= 1'b0;
            timeout <= ~rel_normal;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;
  assign hold_cnt  = cnt;

endmodule

// File: tb/tb_rr_arb3_ctrl.sv
// Testbench for rr_arb3_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_rr_arb3_ctrl;

  localparam int HOLD_MAX = 8;
  localparam int CNT_W    = 4;
`ifdef RR_ARB3_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             CLK;
  logic             RSTn;
  logic [2:0]       req;
  logic             done;
  logic [2:0]       gnt;
  logic [1:0]       owner;
  logic             busy;
  logic             timeout;
  logic [1:0]       state_dbg;
  logic [CNT_W-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  // Model: current owner (-1 = none), previous owner, cycles held, timeout flag.
  int m_owner = -1;
  int m_last  = 2;
  int m_held  = 0;
  bit m_to    = 1'b0;

  rr_arb3_ctrl #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .timeout   (timeout),
    .state_dbg (state_dbg),
    .hold_cnt  (hold_cnt)
  );

  // Clock and initial input values
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    RSTn = 1'b0;
    req  = 3'b000;
    done = 1'b0;
  end

  // Apply one edge of the arbitration rules to the model.
  task automatic model_step(input logic [2:0] r, input logic d, input logic rn);
    if (!rn) begin
      m_owner = -1;
      m_last  = 2;
      m_held  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        if (d || !r[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (TO_EN && m_held == HOLD_MAX) begin
          m_last  = m_owner;
          m_owner = -1;
          m_to    = 1'b1;
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          if (r[(m_last + k) % 3]) begin
            m_owner = (m_last + k) % 3;
            m_held  = 0;
            break;
          end
        end
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [2:0] g;
    logic [1:0] o;
    g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    o = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
    return {g, o, (m_owner >= 0), m_to};
  endfunction

  // Driver: apply inputs, take one edge, update the model, settle.
  task automatic tick(input logic [2:0] r, input logic d, input logic rn);
    req  = r;
    done = d;
    RSTn = rn;
    @(posedge CLK);
    model_step(r, d, rn);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(3'b000, 1'b0, (i >= 2));
      checks++;
      if ({gnt, owner, busy, timeout} !== 7'b000_11_0_0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, {gnt, owner, busy, timeout}, 7'b000_11_0_0);
      end
    end
  endtask

  task automatic test_single();
    int grants;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      tick(3'b010, (m_owner >= 0 && m_held == 2), 1'b1);
      checks++;
      if ({gnt, owner, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b exp=%b", i, {gnt, owner, busy, timeout}, exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (gnt !== 3'b010) begin
          errors++;
          $display("FAIL single_latency got=%b exp=010", gnt);
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    logic [2:0] prev_g;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    prev_g = 3'b000;
    for (int i = 0; i < 16; i++) begin
      tick(3'b111, (m_owner >= 0 && m_held == 1), 1'b1);
      checks++;
      if ({gnt, owner, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL rotation cyc=%0d got=%b exp=%b", i, {gnt, owner, busy, timeout}, exp_vec());
      end
      if (prev_g == 3'b000 && gnt != 3'b000) got_q.push_back(owner);
      prev_g = gnt;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rotation_order idx=%0d got=%0d exp=%0d", i,
                 (i < got_q.size()) ? got_q[i] : 2'bxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_drop();
    logic [2:0] r_seq[6];
    r_seq = '{3'b011, 3'b011, 3'b011, 3'b010, 3'b010, 3'b010};
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(r_seq[i], 1'b0, 1'b1);
      checks++;
      if ({gnt, owner, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL drop cyc=%0d got=%b exp=%b", i, {gnt, owner, busy, timeout}, exp_vec());
      end
      if (i == 3) begin
        checks++;
        if ({gnt, timeout} !== 4'b000_0) begin
          errors++;
          $display("FAIL drop_release got=%b exp=0000", {gnt, timeout});
        end
      end
      if (i == 4) begin
        checks++;
        if (gnt !== 3'b010) begin
          errors++;
          $display("FAIL drop_regrant got=%b exp=010", gnt);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int run;
    int to_cnt;
    bit first_over;
    int exp_run;
    int exp_to;
    run = 0;
    to_cnt = 0;
    first_over = 1'b0;
    exp_run = TO_EN ? HOLD_MAX : 24;
    exp_to  = TO_EN ? 24 / (HOLD_MAX + 1) : 0;
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      tick(3'b001, 1'b0, 1'b1);
      checks++;
      if ({gnt, owner, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", i, {gnt, owner, busy, timeout}, exp_vec());
      end
      if (!first_over) begin
        if (gnt == 3'b001) run++;
        else if (run > 0) first_over = 1'b1;
      end
      if (timeout) to_cnt++;
    end
    checks++;
    if (run != exp_run) begin
      errors++;
      $display("FAIL timeout_hold_len got=%0d exp=%0d", run, exp_run);
    end
    checks++;
    if (to_cnt != exp_to) begin
      errors++;
      $display("FAIL timeout_pulses got=%0d exp=%0d", to_cnt, exp_to);
    end
  endtask

  task automatic test_reset_mid();
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b100, 1'b0, 1'b1);
    tick(3'b100, 1'b0, 1'b1);
    checks++;
    if (gnt !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_pre got=%b exp=100", gnt);
    end
    tick(3'b100, 1'b0, 1'b0);
    checks++;
    if ({gnt, owner, busy, timeout} !== 7'b000_11_0_0) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=%b", {gnt, owner, busy, timeout}, 7'b000_11_0_0);
    end
    tick(3'b101, 1'b0, 1'b1);
    checks++;
    if ({gnt, owner} !== 5'b001_00) begin
      errors++;
      $display("FAIL reset_mid_prio got=%b exp=00100", {gnt, owner});
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic d;
    logic rn;
    for (int i = 0; i < 400; i++) begin
      r  = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 49) != 0);
      tick(r, d, rn);
      checks++;
      if ({gnt, owner, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b done=%b got=%b exp=%b", i, r, d,
                 {gnt, owner, busy, timeout}, exp_vec());
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
